// File: rtl/simon_stream_if.sv
// simon_stream_if
// Host-side sequencer for the SIMON32/64 control core. Collects key and
// plaintext words from a 16-bit valid/ready stream, runs the core's
// newData/readData handshake, then returns the 32-bit result as two 16-bit
// words (high half first) on a valid/ready output stream.
//
// Ports:
//   clk, R                    clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         host input handshake; in_ready only while idle
//   in_cmd, in_data           00 key word, 01 plain word, 10 encrypt, 11 decrypt
//   out_valid/out_ready       result stream handshake
//   out_data                  result word
//   busy, err                 operation in progress, sticky error (cleared by R)
//   newData, readData,
//   enc_dec, plain, key       core inputs (key packed as key[M-1:0][N-1:0])
//   doneKey, doneData, cipher core outputs
//
// Optional build macro SIMON_TIMEOUT_EN adds a watchdog over REQ/HOLD/WAIT
// that aborts to IDLE with err set after 4*T+16 cycles.
module simon_stream_if #(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int T    = 32,
  parameter int HOLD = 2,
  parameter int RD   = 2
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_cmd,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 busy,
  output logic                 err,
  output logic                 newData,
  output logic                 readData,
  output logic                 enc_dec,
  output logic [2*N-1:0]       plain,
  output logic [M-1:0][N-1:0]  key,
  input  logic                 doneKey,
  input  logic                 doneData,
  input  logic [2*N-1:0]       cipher
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_HOLD, S_WAIT, S_READ, S_OUT_HI, S_OUT_LO
  } state_t;

  localparam int CMAX = (HOLD > RD) ? HOLD : RD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int KW   = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(RD - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(M - 1);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   kidx;
  logic            pidx;
  logic            key_full;
  logic [2*N-1:0]  rbuf;
  logic            accept;
  logic            wd_fire;
  logic            wd_abort;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

`ifdef SIMON_TIMEOUT_EN
  localparam int WD_LIMIT = 4*T + 16;
  localparam int WW       = $clog2(4*T + 17);
  logic [WW-1:0] wd_cnt;
  logic          wd_active;

  assign wd_active = (state == S_REQ) || (state == S_HOLD) || (state == S_WAIT);
  assign wd_fire   = wd_active && (wd_cnt == WW'(WD_LIMIT - 1));

  // Watchdog only advances while waiting on the core; any idle cycle rearms it.
  always_ff @(posedge clk or posedge R) begin
    if (R)
      wd_cnt <= '0;
    else if (!wd_active)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge R) begin
    if (R)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // doneKey/doneData are looked at only in REQ and WAIT, so an early doneData
  // cannot shorten the HOLD window.
  always_comb begin
    state_next = state;
    wd_abort   = 1'b0;
    case (state)
      S_IDLE:   if (accept && in_cmd[1] && key_full) state_next = S_REQ;
      S_REQ:    if (doneKey)          state_next = S_HOLD;
      S_HOLD:   if (cnt == HOLD_LAST) state_next = S_WAIT;
      S_WAIT:   if (doneData)         state_next = S_READ;
      S_READ:   if (cnt == RD_LAST)   state_next = S_OUT_HI;
      S_OUT_HI: if (out_ready)        state_next = S_OUT_LO;
      S_OUT_LO: if (out_ready)        state_next = S_IDLE;
      default:                        state_next = S_IDLE;
    endcase
    // A result arriving on the expiry edge still counts as reaching READ.
    if (wd_fire && (state_next != S_READ)) begin
      state_next = S_IDLE;
      wd_abort   = 1'b1;
    end
  end

  // Host-side registers: key/plain assembly, operation mode and error flag.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      key      <= '0;
      plain    <= '0;
      kidx     <= '0;
      pidx     <= 1'b0;
      key_full <= 1'b0;
      enc_dec  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        case (in_cmd)
          2'b00: begin
            key[kidx] <= in_data;
            if (kidx == K_LAST) begin
              kidx     <= '0;
              key_full <= 1'b1;
            end else begin
              kidx <= kidx + 1'b1;
            end
          end
          2'b01: begin
            if (!pidx)
              plain[2*N-1:N] <= in_data;
            else
              plain[N-1:0]   <= in_data;
            pidx <= ~pidx;
          end
          default: begin
            if (key_full) begin
              enc_dec <= ~in_cmd[0];
              pidx    <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        endcase
      end
      if (wd_abort)
        err <= 1'b1;
    end
  end

  // Core-facing and result outputs are registered from the next state so they
  // line up with the state they belong to without any combinational path.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      newData   <= 1'b0;
      readData  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      rbuf      <= '0;
      cnt       <= '0;
    end else begin
      newData   <= (state_next == S_REQ) || (state_next == S_HOLD);
      readData  <= (state_next == S_READ);
      out_valid <= (state_next == S_OUT_HI) || (state_next == S_OUT_LO);
      cnt       <= (state_next != state) ? '0 : cnt + 1'b1;
      if ((state == S_WAIT) && (state_next == S_READ))
        rbuf <= cipher;
      if ((state == S_READ) && (state_next == S_OUT_HI))
        out_data <= rbuf[2*N-1:N];
      if ((state == S_OUT_HI) && (state_next == S_OUT_LO))
        out_data <= rbuf[N-1:0];
    end
  end

endmodule

// File: tb/tb_simon_stream_if.sv
// tb_simon_stream_if
// Self-checking bench for simon_stream_if. A behavioural SIMON32/64 core
// answers the newData/readData handshake; expected results come from a
// host-level model of key/plain loading plus a plain SIMON32/64 function.
`timescale 1ns/1ps
module tb_simon_stream_if;

  localparam int N    = 16;
  localparam int M    = 4;
  localparam int T    = 32;
  localparam int HOLD = 2;
  localparam int RD   = 2;

  logic                clk      = 1'b0;
  logic                R        = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [1:0]          in_cmd   = 2'b00;
  logic [N-1:0]        in_data  = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [N-1:0]        out_data;
  logic                busy, err, newData, readData, enc_dec;
  logic [2*N-1:0]      plain;
  logic [M-1:0][N-1:0] key;
  logic                doneKey  = 1'b0;
  logic                doneData = 1'b0;
  logic [2*N-1:0]      cipher   = '0;

  simon_stream_if #(.N(N), .M(M), .T(T), .HOLD(HOLD), .RD(RD)) dut (
    .clk(clk), .R(R),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err),
    .newData(newData), .readData(readData), .enc_dec(enc_dec),
    .plain(plain), .key(key),
    .doneKey(doneKey), .doneData(doneData), .cipher(cipher)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Plain SIMON32/64: rotations on 16-bit words, z0 sequence of period 31.
  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [31:0] simonRef(input logic [63:0] kin, input logic [31:0] blk,
                                           input logic enc);
    logic [15:0] k [T];
    logic [15:0] x, y, tmp;
    logic [30:0] z;
    z = 31'b1111101000100101011000011100110;
    for (int i = 0; i < M; i++) k[i] = kin[16*i +: 16];
    for (int i = M; i < T; i++) begin
      tmp  = rol(k[i-1], 13) ^ k[i-3];
      tmp  = tmp ^ rol(tmp, 15);
      k[i] = ~k[i-M] ^ tmp ^ {15'd0, z[30 - ((i - M) % 31)]} ^ 16'd3;
    end
    x = blk[31:16];
    y = blk[15:0];
    if (enc) begin
      for (int i = 0; i < T; i++) begin
        tmp = x;
        x   = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
        y   = tmp;
      end
    end else begin
      for (int i = T - 1; i >= 0; i--) begin
        tmp = y;
        y   = x ^ (rol(y, 1) & rol(y, 8)) ^ rol(y, 2) ^ k[i];
        x   = tmp;
      end
    end
    return {x, y};
  endfunction

  // Behavioural core: acknowledges the key after a random delay, then
  // presents the result until readData has come and gone. core_stall keeps
  // doneData low forever; core_early raises doneData together with doneKey.
  bit          core_stall = 1'b0;
  bit          core_early = 1'b0;
  int          cphase = 0;
  int          cdelay = 0;
  logic [31:0] cres   = '0;

  always @(negedge clk or posedge R) begin
    if (R) begin
      cphase   = 0;
      doneKey  = 1'b0;
      doneData = 1'b0;
    end else begin
      case (cphase)
        0: if (newData) begin cdelay = $urandom_range(0, 3); cphase = 1; end
        1: if (cdelay > 0) cdelay--;
           else begin
             cres    = simonRef(key, plain, enc_dec);
             doneKey = 1'b1;
             if (core_early) begin doneData = 1'b1; cipher = cres; end
             cphase  = 2;
           end
        2: if (!newData) begin
             doneKey = 1'b0;
             cdelay  = $urandom_range(0, 4);
             cphase  = core_early ? 4 : 3;
           end
        3: if (cdelay > 0) cdelay--;
           else if (!core_stall) begin doneData = 1'b1; cipher = cres; cphase = 4; end
        4: if (readData) cphase = 5;
        5: if (!readData) begin doneData = 1'b0; cphase = 0; end
        default: cphase = 0;
      endcase
    end
  end

  // Counts post-edge samples with newData and doneKey both high (the HOLD
  // window) and with readData high.
  int hold_cnt = 0;
  int rd_cnt   = 0;
  always @(posedge clk) begin
    #1;
    if (newData && doneKey) hold_cnt++;
    if (readData) rd_cnt++;
  end

  // Host-level model of what the block should hold.
  logic [N-1:0]   mkey [M];
  int             mkidx;
  bit             mfull;
  logic [2*N-1:0] mplain;
  int             mpidx;

  task automatic modelReset();
    for (int i = 0; i < M; i++) mkey[i] = '0;
    mkidx  = 0;
    mfull  = 1'b0;
    mplain = '0;
    mpidx  = 0;
  endtask

  function automatic logic [63:0] modelKey();
    return {mkey[3], mkey[2], mkey[1], mkey[0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Offers one host word from a negedge; returns at the negedge after the
  // transfer edge with in_valid dropped.
  task automatic applyStimulus(input logic [1:0] cmd, input logic [N-1:0] data, output bit took);
    int guard;
    guard    = 0;
    in_cmd   = cmd;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && guard < 400) begin @(negedge clk); guard++; end
    took = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic loadKey(input logic [N-1:0] data);
    bit ok;
    applyStimulus(2'b00, data, ok);
    checkOutput("key_word_taken", 64'(ok), 64'd1);
    mkey[mkidx] = data;
    if (mkidx == M - 1) mfull = 1'b1;
    mkidx = (mkidx + 1) % M;
  endtask

  task automatic loadPlain(input logic [N-1:0] data);
    bit ok;
    applyStimulus(2'b01, data, ok);
    checkOutput("plain_word_taken", 64'(ok), 64'd1);
    if (mpidx == 0) mplain[31:16] = data;
    else            mplain[15:0]  = data;
    mpidx ^= 1;
  endtask

  task automatic doReset();
    @(negedge clk);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    modelReset();
  endtask

  // Waits for a result word, optionally withholds out_ready, then takes it.
  task automatic getWord(input string name, input logic [N-1:0] req, input int stall);
    int guard;
    guard = 0;
    while (!out_valid && guard < 500) begin @(negedge clk); guard++; end
    checkOutput({name, "_valid"}, 64'(out_valid), 64'd1);
    for (int i = 0; i < stall; i++) begin
      checkOutput({name, "_bp_valid"}, 64'(out_valid), 64'd1);
      checkOutput({name, "_bp_data"}, 64'(out_data), 64'(req));
      checkOutput({name, "_bp_in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    checkOutput({name, "_data"}, 64'(out_data), 64'(req));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [31:0] pt, input bit enc,
                       input logic [31:0] req, input int stall);
    bit ok;
    loadPlain(pt[31:16]);
    loadPlain(pt[15:0]);
    hold_cnt = 0;
    rd_cnt   = 0;
    applyStimulus(enc ? 2'b10 : 2'b11, 16'h0, ok);
    mpidx = 0;
    checkOutput({name, "_start_taken"}, 64'(ok), 64'd1);
    checkOutput({name, "_newData_lat"}, 64'(newData), 64'd1);
    checkOutput({name, "_enc_dec"}, 64'(enc_dec), 64'(enc));
    checkOutput({name, "_plain"}, 64'(plain), 64'(mplain));
    checkOutput({name, "_key"}, 64'(key), modelKey());
    checkOutput({name, "_busy"}, 64'(busy), 64'd1);
    getWord({name, "_hi"}, req[31:16], stall);
    getWord({name, "_lo"}, req[15:0], 0);
    checkOutput({name, "_hold_cycles"}, 64'(hold_cnt), 64'(HOLD));
    checkOutput({name, "_read_cycles"}, 64'(rd_cnt), 64'(RD));
    checkOutput({name, "_end_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({name, "_end_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({name, "_err"}, 64'(err), 64'd0);
  endtask

  typedef struct {
    logic [31:0] pt;
    bit          enc;
    logic [31:0] req;
    int          stall;
    bit          early;
  } vec_t;

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t        vecs [4];
    bit          ok;
    int          guard;
    logic [31:0] pt;
    bit          enc;

    vecs[0] = '{32'h65656877, 1'b1, 32'hc69be9bb, 5, 1'b0};
    vecs[1] = '{32'hc69be9bb, 1'b0, 32'h65656877, 0, 1'b0};
    vecs[2] = '{32'h65656877, 1'b1, 32'hc69be9bb, 1, 1'b1};
    vecs[3] = '{32'hc69be9bb, 1'b0, 32'h65656877, 0, 1'b1};

    modelReset();
    repeat (2) @(negedge clk);
    R = 1'b0;

    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_newData", 64'(newData), 64'd0);
    checkOutput("rst_readData", 64'(readData), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_enc_dec", 64'(enc_dec), 64'd0);
    checkOutput("rst_key", 64'(key), 64'd0);
    checkOutput("rst_plain", 64'(plain), 64'd0);

    // Start with an incomplete key: word consumed, err set, no core request.
    loadKey(16'h0100);
    loadKey(16'h0908);
    loadKey(16'h1110);
    applyStimulus(2'b10, 16'h0, ok);
    checkOutput("nokey_start_taken", 64'(ok), 64'd1);
    checkOutput("nokey_err", 64'(err), 64'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("nokey_newData", 64'(newData), 64'd0);
      checkOutput("nokey_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    doReset();
    checkOutput("err_cleared", 64'(err), 64'd0);

    $display("[TB] directed vectors");
    loadKey(16'h0100);
    loadKey(16'h0908);
    loadKey(16'h1110);
    loadKey(16'h1918);
    checkOutput("key_loaded", 64'(key), 64'h1918111009080100);
    for (int i = 0; i < 4; i++) begin
      core_early = vecs[i].early;
      runOp($sformatf("vec%0d", i), vecs[i].pt, vecs[i].enc, vecs[i].req, vecs[i].stall);
    end
    core_early = 1'b0;

    $display("[TB] randomized operations");
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        int nk;
        nk = $urandom_range(4, 5);
        for (int j = 0; j < nk; j++) loadKey(16'($urandom));
      end
      pt  = $urandom;
      enc = 1'($urandom_range(0, 1));
      core_early = 1'($urandom_range(0, 1));
      runOp($sformatf("rnd%0d", it), pt, enc, simonRef(modelKey(), pt, enc),
            $urandom_range(0, 2));
    end
    core_early = 1'b0;

    $display("[TB] reset while waiting for doneData");
    core_stall = 1'b1;
    loadPlain(16'h1234);
    loadPlain(16'h5678);
    applyStimulus(2'b10, 16'h0, ok);
    guard = 0;
    while (newData && guard < 200) begin @(negedge clk); guard++; end
    checkOutput("wait_reached", 64'(newData), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("wait_busy", 64'(busy), 64'd1);
    R = 1'b1;
    #1;
    checkOutput("abort_newData", 64'(newData), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_edge_newData", 64'(newData), 64'd0);
    checkOutput("abort_edge_busy", 64'(busy), 64'd0);
    checkOutput("abort_edge_err", 64'(err), 64'd0);
    checkOutput("abort_edge_key", 64'(key), 64'd0);
    @(negedge clk);
    R = 1'b0;
    core_stall = 1'b0;
    modelReset();
    applyStimulus(2'b10, 16'h0, ok);
    checkOutput("abort_restart_err", 64'(err), 64'd1);
    checkOutput("abort_restart_newData", 64'(newData), 64'd0);
    doReset();

`ifdef SIMON_TIMEOUT_EN
    $display("[TB] watchdog with silent core");
    loadKey(16'h0100);
    loadKey(16'h0908);
    loadKey(16'h1110);
    loadKey(16'h1918);
    loadPlain(16'h6565);
    loadPlain(16'h6877);
    core_stall = 1'b1;
    applyStimulus(2'b10, 16'h0, ok);
    repeat (4*T + 16 - 4) @(negedge clk);
    checkOutput("wd_before_busy", 64'(busy), 64'd1);
    checkOutput("wd_before_err", 64'(err), 64'd0);
    repeat (8) @(negedge clk);
    checkOutput("wd_err", 64'(err), 64'd1);
    checkOutput("wd_in_ready", 64'(in_ready), 64'd1);
    checkOutput("wd_newData", 64'(newData), 64'd0);
    core_stall = 1'b0;
    doReset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_stream_if.md
Name: simon_stream_if

Overview:
- Host-side sequencer for the SIMON32/64 control core.
- Assembles key and plaintext words from a 16-bit valid/ready input stream.
- Drives the core's newData/readData handshake, captures the result, and returns it as a 16-bit valid/ready output stream.
- Sits between the host bus and the SIMON control core; it is the only agent driving the core's inputs.

Parameters:
- N, 16, word width (half block)
- M, 4, key words
- T, 32, cipher rounds; used for timeout sizing only
- HOLD, 2, cycles newData stays high after doneKey is seen
- RD, 2, cycles readData stays high

Ports:
- clk  in  1  clock, rising edge
- R  in  1  asynchronous active-high reset
- in_valid  in  1  host word valid
- in_ready  out  1  block accepts word
- in_cmd  in  2  00 key word, 01 plain word, 10 start encrypt, 11 start decrypt
- in_data  in  N  host word; ignored for start commands
- out_valid  out  1  result word valid
- out_ready  in  1  host accepts result word
- out_data  out  N  result word
- busy  out  1  operation in progress
- err  out  1  sticky error flag; cleared only by R
- newData  out  1  to core
- readData  out  1  to core
- enc_dec  out  1  to core; 1 = encrypt
- plain  out  2N  to core
- key  out  M*N  to core, packed as key[M-1:0][N-1:0]
- doneKey  in  1  from core
- doneData  in  1  from core
- cipher  in  2N  from core

Behaviour:
- Reset values: all outputs 0; key, plain and counters 0; key_full flag 0; state IDLE.
  - R asserted mid-operation aborts immediately; out_valid drops at once.
- A transfer occurs on a rising clk edge with in_valid && in_ready.
  - in_ready = 1 only in IDLE.
- Key word: written to key[kidx]; kidx increments mod M.
  - key_full is set when kidx wraps from M-1 to 0.
  - A fifth word overwrites key[0].
- Plain word: pidx 0 writes plain[2N-1:N], pidx 1 writes plain[N-1:0]; pidx toggles.
- Start command:
  - If key_full = 0: set err, stay in IDLE, word consumed.
  - Otherwise: enc_dec <= ~in_cmd[0]; pidx <= 0; go to REQ.
- States:
  - IDLE: busy = 0.
  - REQ: newData = 1; wait for doneKey = 1, then go to HOLD.
  - HOLD: newData = 1 for HOLD cycles (counter), then newData = 0; go to WAIT.
  - WAIT: wait for doneData = 1, then go to READ.
  - READ: capture cipher into rbuf on entry; readData = 1 for RD cycles; go to OUT_HI.
  - OUT_HI: out_valid = 1, out_data = rbuf[2N-1:N]; on out_ready go to OUT_LO.
  - OUT_LO: out_valid = 1, out_data = rbuf[N-1:0]; on out_ready go to IDLE.
- busy = 1 in every state except IDLE.
- Latency: start accepted to newData high = 1 cycle.
- out_valid behaviour:
  - Once high, it holds with out_data stable until accepted.
  - No combinational path from out_ready to out_valid.
- doneKey/doneData levels are sampled only in the states listed.
  - A doneData already high in HOLD does not skip HOLD.
- Key registers persist across operations; only plain needs reloading.
  - Load order and contents are unchanged by a run.
- All outputs are registered except in_ready and busy, which are decoded from state.

Optional Feature:
- Macro: SIMON_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in REQ, HOLD and WAIT.
  - If the count reaches 4*T+16 cycles without reaching READ: set err, force newData = 0, return to IDLE.
  - Counter width is $clog2(4*T+17).
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Load key words 0100, 0908, 1110, 1918 (key[0] first), plain 6565 then 6877, start encrypt with a behavioural core:
  - enc_dec = 1; newData rises 1 cycle after the start.
  - newData falls exactly HOLD cycles after doneKey.
  - readData high 2 cycles.
  - Output words c69b then e9bb.
- Feed c69b, e9bb as plain, start decrypt:
  - enc_dec = 0; outputs 6565 then 6877.
  - Key reload is not required.
- Start encrypt after reset with only 3 key words loaded:
  - err = 1, newData never rises, in_ready stays 1.
- Hold out_ready = 0 for 5 cycles in OUT_HI:
  - out_valid stays 1, out_data = c69b stable.
  - in_ready = 0 throughout.
- Assert R in WAIT:
  - Next edge shows newData = 0, busy = 0, err = 0, key = 0.
  - A subsequent start sets err.
- With SIMON_TIMEOUT_EN defined, the core never asserts doneData:
  - After 144 cycles, err = 1 and state returns to IDLE (in_ready = 1).
